edge_event_arbiter: RTL and testbench

Captures rising (optionally falling) edges on N single-bit synchronous inputs, holds each as a pending event, and schedules the events round-robin onto one shared valid/ready event channel. Sits between the per-signal edge detectors and the single downstream event consumer (interrupt/status logic), so no edge is lost while the consumer is busy, up to one pending event per source.

---
 rtl/edge_arb_pkg.sv | 23 ++
 rtl/edge_det.sv | 21 ++
 rtl/edge_event_arbiter.sv | 128 ++++++++++++
 tb/tb_edge_event_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/edge_arb_pkg.sv
// Shared types and sizing helpers for the edge event arbiter.
// The FALLING_EDGE_EN build option is handled in edge_event_arbiter.
package edge_arb_pkg;

  localparam int DEF_N   = 4;
  localparam int MAX_IDW = 4;

  typedef enum logic {
    EVT_RISE = 1'b0,
    EVT_FALL = 1'b1
  } evt_kind;

  // id is sized for the largest supported channel count (16)
  typedef struct packed {
    logic [MAX_IDW-1:0] id;
    evt_kind            kind;
  } evt_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_det.sv
// One-bit edge detector on an input already synchronous to clk.
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic a,
  output logic rise,
  output logic fall
);

  logic a_prev;

  // a_prev clears on reset so a level already high afterwards counts as a rise
  always_ff @(posedge clk) begin
    if (reset) a_prev <= 1'b0;
    else       a_prev <= a;
  end

  assign rise = a & ~a_prev;
  assign fall = ~a & a_prev;

endmodule

// File: rtl/edge_event_arbiter.sv
// Captures per-channel edges as pending events and serves them round-robin on one
// valid/ready channel. Define FALLING_EDGE_EN to also capture falling edges.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int IDW = id_width(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   a_i,
  output logic           evt_valid_o,
  input  logic           evt_ready_i,
  output logic [IDW-1:0] evt_id_o,
  output logic           evt_fall_o,
  output logic [N-1:0]   ovf_o,
  input  logic [N-1:0]   ovf_clr_i
);

`ifdef FALLING_EDGE_EN
  localparam int S = 2 * N;
`else
  localparam int S = N;
`endif
  localparam int SW = (S > 1) ? $clog2(S) : 1;

  logic [N-1:0]  rise;
  logic [N-1:0]  fall;
  logic [S-1:0]  src_edge;
  logic [S-1:0]  pending;
  logic [S-1:0]  taken;
  logic [S-1:0]  lost;
  logic [N-1:0]  ovf_set;
  logic [SW-1:0] start_ptr;
  logic [SW-1:0] win;
  logic          found;
  logic          load;
  evt_t          evt_q;

  function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int off);
    int t;
    t = int'(base) + off;
    if (t >= S) t = t - S;
    return SW'(t);
  endfunction

  function automatic evt_t make_evt(input logic [SW-1:0] src);
    evt_t e;
`ifdef FALLING_EDGE_EN
    e.id   = MAX_IDW'(src >> 1);
    e.kind = src[0] ? EVT_FALL : EVT_RISE;
`else
    e.id   = MAX_IDW'(src);
    e.kind = EVT_RISE;
`endif
    return e;
  endfunction

  for (genvar c = 0; c < N; c++) begin : g_det
    edge_det u_det (
      .clk   (clk),
      .reset (reset),
      .a     (a_i[c]),
      .rise  (rise[c]),
      .fall  (fall[c])
    );
  end

  // Sources interleave rise0, fall0, rise1, ... when falling edges are enabled
`ifdef FALLING_EDGE_EN
  always_comb begin
    src_edge = '0;
    ovf_set  = '0;
    for (int c = 0; c < N; c++) begin
      src_edge[2*c]   = rise[c];
      src_edge[2*c+1] = fall[c];
      ovf_set[c]      = lost[2*c] | lost[2*c+1];
    end
  end
`else
  wire unused_fall = ^fall;

  always_comb begin
    src_edge = rise;
    ovf_set  = lost;
  end
`endif

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < S; i++) begin
      if (!found && pending[wrap_add(start_ptr, i)]) begin
        found = 1'b1;
        win   = wrap_add(start_ptr, i);
      end
    end
  end

  assign load  = !evt_valid_o || evt_ready_i;
  assign taken = (load && found) ? (S'(1) << win) : '0;
  assign lost  = src_edge & pending & ~taken;

  // An edge arriving while its source is being loaded re-arms pending without loss
  always_ff @(posedge clk) begin
    if (reset) begin
      pending     <= '0;
      evt_valid_o <= 1'b0;
      evt_q       <= '0;
      ovf_o       <= '0;
      start_ptr   <= '0;
    end else begin
      pending <= (pending & ~taken) | src_edge;
      ovf_o   <= (ovf_o & ~ovf_clr_i) | ovf_set;
      if (load) begin
        evt_valid_o <= found;
        if (found) begin
          evt_q     <= make_evt(win);
          start_ptr <= wrap_add(win, 1);
        end
      end
    end
  end

  assign evt_id_o   = IDW'(evt_q.id);
  assign evt_fall_o = (evt_q.kind == EVT_FALL);

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter; expectations adapt when FALLING_EDGE_EN is defined.
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] a_i;
  logic       evt_valid_o;
  logic       evt_ready_i;
  logic [1:0] evt_id_o;
  logic       evt_fall_o;
  logic [3:0] ovf_o;
  logic [3:0] ovf_clr_i;

  typedef struct packed {
    logic [1:0] id;
    logic       fall;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  edge_event_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .a_i         (a_i),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_id_o    (evt_id_o),
    .evt_fall_o  (evt_fall_o),
    .ovf_o       (ovf_o),
    .ovf_clr_i   (ovf_clr_i)
  );

  always #5 clk = ~clk;

  task automatic pushExp(input logic [1:0] id, input logic fall);
    exp_t e;
    e.id   = id;
    e.fall = fall;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic rdy, input logic [3:0] clr,
                               input int cycles);
    a_i         = a;
    evt_ready_i = rdy;
    ovf_clr_i   = clr;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    reset       = 1'b1;
    a_i         = 4'b0000;
    evt_ready_i = 1'b0;
    ovf_clr_i   = 4'b0000;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Every accepted transfer is matched against the oldest expected event
  always @(negedge clk) begin
    if (!reset && evt_valid_o && evt_ready_i) begin
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_event: got id=%0d fall=%0d expected none",
                 evt_id_o, evt_fall_o);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        if (evt_id_o !== e.id || evt_fall_o !== e.fall) begin
          mismatched++;
          $display("[TB] FAIL event: got id=%0d fall=%0d expected id=%0d fall=%0d",
                   evt_id_o, evt_fall_o, e.id, e.fall);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset state, then an input high at reset release becomes a rising event
    reset       = 1'b1;
    a_i         = 4'b0001;
    evt_ready_i = 1'b0;
    ovf_clr_i   = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", evt_valid_o, 0);
    checkOutput("reset_id", evt_id_o, 0);
    checkOutput("reset_fall", evt_fall_o, 0);
    checkOutput("reset_ovf", ovf_o, 0);
    pushExp(2'd0, 1'b0);
    reset = 1'b0;
    applyStimulus(4'b0001, 1'b0, 4'b0000, 1);
    checkOutput("latency_e0_valid", evt_valid_o, 0);
    applyStimulus(4'b0001, 1'b0, 4'b0000, 1);
    checkOutput("latency_e1_valid", evt_valid_o, 1);
    checkOutput("latency_e1_id", evt_id_o, 0);
    checkOutput("latency_e1_fall", evt_fall_o, 0);
    applyStimulus(4'b0001, 1'b1, 4'b0000, 1);
    checkOutput("drained_valid", evt_valid_o, 0);
    doReset();

    // Simultaneous rises drain back-to-back in channel order
    pushExp(2'd0, 1'b0);
    pushExp(2'd2, 1'b0);
    pushExp(2'd3, 1'b0);
    applyStimulus(4'b1101, 1'b1, 4'b0000, 2);
    checkOutput("b2b_valid0", evt_valid_o, 1);
    checkOutput("b2b_id0", evt_id_o, 0);
    applyStimulus(4'b1101, 1'b1, 4'b0000, 1);
    checkOutput("b2b_valid1", evt_valid_o, 1);
    checkOutput("b2b_id1", evt_id_o, 2);
    applyStimulus(4'b1101, 1'b1, 4'b0000, 1);
    checkOutput("b2b_valid2", evt_valid_o, 1);
    checkOutput("b2b_id2", evt_id_o, 3);
    applyStimulus(4'b1101, 1'b1, 4'b0000, 1);
    checkOutput("b2b_end_valid", evt_valid_o, 0);
    doReset();

    // Repeated ch1 rises with the consumer stalled overflow the pending slot
    applyStimulus(4'b0010, 1'b0, 4'b0000, 1);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1);
    applyStimulus(4'b0010, 1'b0, 4'b0000, 1);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1);
`ifndef FALLING_EDGE_EN
    checkOutput("ovf_not_yet", ovf_o, 4'b0000);
`endif
    applyStimulus(4'b0010, 1'b0, 4'b0000, 1);
    checkOutput("ovf_set", ovf_o, 4'b0010);
    checkOutput("held_valid", evt_valid_o, 1);
    checkOutput("held_id", evt_id_o, 1);
    checkOutput("held_fall", evt_fall_o, 0);
    applyStimulus(4'b0010, 1'b0, 4'b0010, 1);
    checkOutput("ovf_cleared", ovf_o, 4'b0000);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1);
    applyStimulus(4'b0010, 1'b0, 4'b0010, 1);
    checkOutput("ovf_set_beats_clr", ovf_o, 4'b0010);
    applyStimulus(4'b0010, 1'b0, 4'b0010, 1);
    checkOutput("ovf_cleared2", ovf_o, 4'b0000);
    pushExp(2'd1, 1'b0);
`ifdef FALLING_EDGE_EN
    pushExp(2'd1, 1'b1);
`endif
    pushExp(2'd1, 1'b0);
    applyStimulus(4'b0010, 1'b1, 4'b0000, 4);
    checkOutput("ovf_drain_valid", evt_valid_o, 0);
    doReset();

    // After ch1 is granted, pending ch0 and ch2 are served ch2 first, then ch0
    pushExp(2'd1, 1'b0);
    pushExp(2'd2, 1'b0);
    pushExp(2'd0, 1'b0);
    applyStimulus(4'b0010, 1'b1, 4'b0000, 2);
    applyStimulus(4'b0111, 1'b1, 4'b0000, 2);
    checkOutput("rr_first_id", evt_id_o, 2);
    applyStimulus(4'b0111, 1'b1, 4'b0000, 1);
    checkOutput("rr_wrap_id", evt_id_o, 0);
    applyStimulus(4'b0111, 1'b1, 4'b0000, 1);
    checkOutput("rr_end_valid", evt_valid_o, 0);
    doReset();

    // A three-cycle pulse on ch2 yields a rise, plus a fall when enabled
    pushExp(2'd2, 1'b0);
`ifdef FALLING_EDGE_EN
    pushExp(2'd2, 1'b1);
`endif
    applyStimulus(4'b0100, 1'b1, 4'b0000, 3);
    applyStimulus(4'b0000, 1'b1, 4'b0000, 4);
    checkOutput("pulse_end_valid", evt_valid_o, 0);
    doReset();

    // Reset mid-operation discards the presented event and all pending ones
    applyStimulus(4'b1011, 1'b0, 4'b0000, 2);
    checkOutput("pre_reset_valid", evt_valid_o, 1);
    checkOutput("pre_reset_id", evt_id_o, 0);
    doReset();
    checkOutput("mid_reset_valid", evt_valid_o, 0);
    checkOutput("mid_reset_ovf", ovf_o, 0);
    applyStimulus(4'b0000, 1'b1, 4'b0000, 6);
    checkOutput("post_reset_valid", evt_valid_o, 0);

    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
